plb_dac_streamer: RTL and testbench

Parametrised successor to the single-channel PLB DAC output path. It buffers processor-written samples in a FIFO and replays them to an external parallel DAC at a programmable sample rate. Samples for C_NUM_CH channels are interleaved, with a channel-select pin and a data clock. It sits between the PLB slave register file (push side) and the DAC pins, and adds rate division, format conversion, underrun handling and power-down sequencing.

---
 rtl/plb_dac_streamer.sv | 243 ++++++++++++++++++++++++
 tb/tb_plb_dac_streamer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plb_dac_streamer.sv
// Sample FIFO plus rate-divided, channel-interleaved replay to a parallel DAC.
// Optional DAC_UNDERRUN_HOLD_EN: underruns repeat each channel's last output instead of midscale.
module plb_dac_streamer #(
    parameter int C_DATA_WIDTH = 10,
    parameter int C_NUM_CH     = 2,
    parameter int C_FIFO_DEPTH = 16,
    parameter int C_DIV_WIDTH  = 16
) (
    input  logic                                            Bus2IP_Clk,
    input  logic                                            Bus2IP_Reset,
    input  logic                                            wr_valid,
    input  logic [C_DATA_WIDTH-1:0]                         wr_data,
    output logic                                            wr_ready,
    input  logic                                            ctl_enable,
    input  logic [C_DIV_WIDTH-1:0]                          ctl_rate_div,
    input  logic                                            ctl_offset_bin,
    input  logic                                            ctl_pwrdn_req,
    input  logic                                            underrun_clr,
    output logic [$clog2(C_FIFO_DEPTH):0]                   fifo_level,
    output logic [15:0]                                     underrun_cnt,
    output logic                                            busy,
    output logic [C_DATA_WIDTH-1:0]                         S_Data,
    output logic                                            S_DCLKIO,
    output logic [((C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1)-1:0] S_Sel,
    output logic                                            S_PWRDN
);
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1;
    localparam logic [C_DATA_WIDTH-1:0] MSB_MASK = C_DATA_WIDTH'(1'b1) << (C_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_PWRDN = 3'd4
    } state_t;

    function automatic logic [C_DATA_WIDTH-1:0] to_dac_fmt(input logic [C_DATA_WIDTH-1:0] s,
                                                          input logic offset_bin);
        return offset_bin ? (s ^ MSB_MASK) : s;
    endfunction

    logic [C_DATA_WIDTH-1:0] mem_r [C_FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_r;
    logic [AW-1:0]           rd_ptr_r;
    logic [LW-1:0]           level_r;
    logic [LW-1:0]           level_nxt_s;
    logic                    ready_r;
    state_t                  state_r;
    logic [C_DIV_WIDTH-1:0]  div_r;
    logic [C_DIV_WIDTH-1:0]  cnt_r;
    logic [C_DIV_WIDTH-1:0]  cnt_nxt_s;
    logic [C_DIV_WIDTH-1:0]  half_s;
    logic [C_DIV_WIDTH-1:0]  rate_nz_s;
    logic [SW-1:0]           ch_r;
    logic [SW-1:0]           ch_nxt_s;
    logic [15:0]             urun_r;
    logic [C_DATA_WIDTH-1:0] data_r;
    logic [SW-1:0]           sel_r;
    logic                    dclk_r;
    logic                    busy_r;
    logic                    pwrdn_r;
    logic                    push_s;
    logic                    pop_s;
    logic                    tick_s;
    logic                    empty_s;
    logic                    underrun_s;
    logic                    last_ch_s;
    logic [C_DATA_WIDTH-1:0] fmt_s;
    logic [C_DATA_WIDTH-1:0] mid_s;
    logic [C_DATA_WIDTH-1:0] fill_s;
    logic [C_DATA_WIDTH-1:0] out_s;

    assign push_s      = wr_valid & ready_r;
    assign empty_s     = (level_r == {LW{1'b0}});
    assign tick_s      = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && (cnt_r == {C_DIV_WIDTH{1'b0}});
    assign pop_s       = tick_s & ~empty_s;
    assign underrun_s  = tick_s & empty_s;
    assign last_ch_s   = (ch_r == SW'(C_NUM_CH - 1));
    assign ch_nxt_s    = last_ch_s ? {SW{1'b0}} : (ch_r + SW'(1'b1));
    assign cnt_nxt_s   = tick_s ? div_r : (cnt_r - C_DIV_WIDTH'(1'b1));
    assign half_s      = div_r >> 1'b1;
    assign rate_nz_s   = (ctl_rate_div == {C_DIV_WIDTH{1'b0}}) ? C_DIV_WIDTH'(1'b1) : ctl_rate_div;
    assign fmt_s       = to_dac_fmt(mem_r[rd_ptr_r], ctl_offset_bin);
    assign mid_s       = ctl_offset_bin ? MSB_MASK : {C_DATA_WIDTH{1'b0}};
    assign out_s       = pop_s ? fmt_s : fill_s;

`ifdef DAC_UNDERRUN_HOLD_EN
    logic [C_DATA_WIDTH-1:0] hold_r [C_NUM_CH];
    logic [C_NUM_CH-1:0]     hold_vld_r;

    assign fill_s = hold_vld_r[ch_r] ? hold_r[ch_r] : mid_s;

    // Per-channel record of the last real sample driven, for underrun repeat
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                hold_r[i] <= {C_DATA_WIDTH{1'b0}};
            end
            hold_vld_r <= {C_NUM_CH{1'b0}};
        end else if (pop_s) begin
            hold_r[ch_r]     <= fmt_s;
            hold_vld_r[ch_r] <= 1'b1;
        end
    end
`else
    assign fill_s = mid_s;
`endif

    // Next FIFO occupancy; a same-cycle push and pop cancel
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1'b1);
            2'b01:   level_nxt_s = level_r - LW'(1'b1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Sample storage; contents are don't-care outside the occupied window
    always_ff @(posedge Bus2IP_Clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, level and a ready flag derived from the next level
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            level_r <= level_nxt_s;
            ready_r <= (level_nxt_s != LW'(C_FIFO_DEPTH));
        end
    end

    // Saturating underrun counter; clear wins over a same-cycle increment
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            urun_r <= 16'h0000;
        end else if (underrun_clr) begin
            urun_r <= 16'h0000;
        end else if (underrun_s && (urun_r != 16'hFFFF)) begin
            urun_r <= urun_r + 16'h0001;
        end
    end

    // Streaming FSM with divider, channel counter and registered DAC pins
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_r <= ST_IDLE;
            div_r   <= {C_DIV_WIDTH{1'b0}};
            cnt_r   <= {C_DIV_WIDTH{1'b0}};
            ch_r    <= {SW{1'b0}};
            data_r  <= {C_DATA_WIDTH{1'b0}};
            sel_r   <= {SW{1'b0}};
            dclk_r  <= 1'b0;
            busy_r  <= 1'b0;
            pwrdn_r <= 1'b0;
        end else begin
            if (tick_s) begin
                data_r <= out_s;
                sel_r  <= ch_r;
                ch_r   <= ch_nxt_s;
            end
            case (state_r)
                ST_IDLE: begin
                    dclk_r <= 1'b0;
                    if (ctl_enable) begin
                        state_r <= ST_PRIME;
                        busy_r  <= 1'b1;
                    end else if (ctl_pwrdn_req) begin
                        state_r <= ST_PWRDN;
                        pwrdn_r <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (!ctl_enable) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (level_r >= LW'(C_NUM_CH)) begin
                        div_r   <= rate_nz_s;
                        cnt_r   <= rate_nz_s;
                        ch_r    <= {SW{1'b0}};
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Clock output tracks the count so its rising edge lands mid-period
                    cnt_r  <= cnt_nxt_s;
                    dclk_r <= (cnt_nxt_s <= half_s);
                    if (!ctl_enable) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    cnt_r <= cnt_nxt_s;
                    if (tick_s && last_ch_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        dclk_r  <= 1'b0;
                    end else begin
                        dclk_r <= (cnt_nxt_s <= half_s);
                    end
                end
                ST_PWRDN: begin
                    dclk_r <= 1'b0;
                    if (!ctl_pwrdn_req) begin
                        state_r <= ST_IDLE;
                        pwrdn_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    dclk_r  <= 1'b0;
                    pwrdn_r <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready     = ready_r;
    assign fifo_level   = level_r;
    assign underrun_cnt = urun_r;
    assign busy         = busy_r;
    assign S_Data       = data_r;
    assign S_DCLKIO     = dclk_r;
    assign S_Sel        = sel_r;
    assign S_PWRDN      = pwrdn_r;

endmodule

// File: tb/tb_plb_dac_streamer.sv
// Randomized bench for plb_dac_streamer against a queue-based sample/tick model.
module tb_plb_dac_streamer;
    localparam int W     = 10;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam logic [W-1:0] MID = W'(1'b1) << (W - 1);

    logic            Bus2IP_Clk = 1'b0;
    logic            Bus2IP_Reset;
    logic            wr_valid;
    logic [W-1:0]    wr_data;
    logic            wr_ready;
    logic            ctl_enable;
    logic [DW-1:0]   ctl_rate_div;
    logic            ctl_offset_bin;
    logic            ctl_pwrdn_req;
    logic            underrun_clr;
    logic [4:0]      fifo_level;
    logic [15:0]     underrun_cnt;
    logic            busy;
    logic [W-1:0]    S_Data;
    logic            S_DCLKIO;
    logic [0:0]      S_Sel;
    logic            S_PWRDN;

    plb_dac_streamer #(
        .C_DATA_WIDTH(W), .C_NUM_CH(NCH), .C_FIFO_DEPTH(DEPTH), .C_DIV_WIDTH(DW)
    ) dut (
        .Bus2IP_Clk(Bus2IP_Clk), .Bus2IP_Reset(Bus2IP_Reset),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .ctl_enable(ctl_enable), .ctl_rate_div(ctl_rate_div),
        .ctl_offset_bin(ctl_offset_bin), .ctl_pwrdn_req(ctl_pwrdn_req),
        .underrun_clr(underrun_clr), .fifo_level(fifo_level),
        .underrun_cnt(underrun_cnt), .busy(busy), .S_Data(S_Data),
        .S_DCLKIO(S_DCLKIO), .S_Sel(S_Sel), .S_PWRDN(S_PWRDN)
    );

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] model_q[$];
    int           model_ch;
    logic [15:0]  model_urun;
    logic [W-1:0] model_hold [NCH];
    bit           model_hold_vld [NCH];
    bit           last_clr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] fmt(input logic [W-1:0] s, input logic ob);
        return ob ? (s ^ MID) : s;
    endfunction

    task automatic step();
        last_clr = underrun_clr;
        @(posedge Bus2IP_Clk);
        #1;
        if (last_clr) model_urun = 16'h0000;
    endtask

    task automatic model_clear();
        model_q.delete();
        model_ch   = 0;
        model_urun = 16'h0000;
        for (int i = 0; i < NCH; i++) begin
            model_hold[i]     = '0;
            model_hold_vld[i] = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
        check({tag, "_urun"}, 32'(underrun_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_data"}, 32'(S_Data), 32'd0);
        check({tag, "_dclk"}, 32'(S_DCLKIO), 32'd0);
        check({tag, "_sel"}, 32'(S_Sel), 32'd0);
        check({tag, "_pwrdn"}, 32'(S_PWRDN), 32'd0);
    endtask

    task automatic do_reset();
        Bus2IP_Reset = 1'b1;
        step();
        model_clear();
        check_zero("reset");
        Bus2IP_Reset = 1'b0;
        step();
        check("ready_after_reset", 32'(wr_ready), 32'd1);
    endtask

    task automatic push(input logic [W-1:0] d);
        check("push_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
        model_q.push_back(d);
        check("push_level", 32'(fifo_level), 32'(model_q.size()));
    endtask

    // Called right after the edge on which a tick was expected
    task automatic expect_tick();
        logic [W-1:0] exp_d;
        if (model_q.size() > 0) begin
            exp_d = fmt(model_q.pop_front(), ctl_offset_bin);
            model_hold[model_ch]     = exp_d;
            model_hold_vld[model_ch] = 1'b1;
        end else begin
            exp_d = ctl_offset_bin ? MID : '0;
`ifdef DAC_UNDERRUN_HOLD_EN
            if (model_hold_vld[model_ch]) exp_d = model_hold[model_ch];
`endif
            if (!last_clr && model_urun != 16'hFFFF) model_urun = model_urun + 16'h0001;
        end
        check("s_data", 32'(S_Data), 32'(exp_d));
        check("s_sel", 32'(S_Sel), 32'(model_ch));
        check("underrun_cnt", 32'(underrun_cnt), 32'(model_urun));
        check("tick_level", 32'(fifo_level), 32'(model_q.size()));
        model_ch = (model_ch + 1) % NCH;
    endtask

    // Enable, stream n_ticks, drop enable, then follow the drain to IDLE
    task automatic run_stream(input int div, input bit ob, input int n_ticks);
        int  deff;
        int  out_ch;
        bit  dropped;
        bit  exp_clk;
        deff           = (div == 0) ? 1 : div;
        ctl_rate_div   = DW'(div);
        ctl_offset_bin = ob;
        ctl_enable     = 1'b1;
        step();
        check("busy_prime", 32'(busy), 32'd1);
        step();
        model_ch = 0;
        dropped  = 1'b0;
        for (int t = 0; t < n_ticks + NCH + 1; t++) begin
            for (int j = 1; j <= deff + 1; j++) begin
                step();
                exp_clk = (j <= deff) ? ((deff - j) <= (deff / 2)) : 1'b0;
                check("dclk_phase", 32'(S_DCLKIO), 32'(exp_clk));
            end
            out_ch = model_ch;
            expect_tick();
            if (dropped && out_ch == NCH - 1) break;
            check("busy_run", 32'(busy), 32'd1);
            if (!dropped && t + 1 >= n_ticks) begin
                ctl_enable = 1'b0;
                dropped    = 1'b1;
            end
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_dclk", 32'(S_DCLKIO), 32'd0);
        step();
        check("idle_hold_data_dclk", 32'(S_DCLKIO), 32'd0);
        check("idle_level", 32'(fifo_level), 32'(model_q.size()));
    endtask

    initial begin
        int n_push;
        Bus2IP_Reset   = 1'b1;
        wr_valid       = 1'b0;
        wr_data        = '0;
        ctl_enable     = 1'b0;
        ctl_rate_div   = '0;
        ctl_offset_bin = 1'b1;
        ctl_pwrdn_req  = 1'b0;
        underrun_clr   = 1'b0;
        last_clr       = 1'b0;
        model_clear();
        step();
        do_reset();
        ctl_offset_bin = 1'b0;

        // Directed: basic stream, drop enable while channel 0 is out
        push(10'h001); push(10'h3FF); push(10'h200); push(10'h1FF);
        run_stream(3, 1'b0, 3);

        // Power-down from IDLE; enable ignored while powered down
        ctl_pwrdn_req = 1'b1;
        step();
        check("pwrdn_on", 32'(S_PWRDN), 32'd1);
        check("pwrdn_busy", 32'(busy), 32'd0);
        ctl_enable = 1'b1;
        step();
        check("pwrdn_ign_en", 32'(busy), 32'd0);
        check("pwrdn_still", 32'(S_PWRDN), 32'd1);
        ctl_enable    = 1'b0;
        ctl_pwrdn_req = 1'b0;
        step();
        check("pwrdn_off", 32'(S_PWRDN), 32'd0);

        // Underrun after three samples at the fastest rate
        push(10'h155); push(10'h0AA); push(10'h2C3);
        run_stream(1, 1'b0, 5);

        // Offset binary conversion
        push(10'h000); push(10'h200);
        run_stream(0, 1'b1, 1);

        // Clear pulse, then clear held across underrunning ticks
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("urun_clr", 32'(underrun_cnt), 32'd0);
        push(10'h123); push(10'h321);
        underrun_clr = 1'b1;
        run_stream(0, 1'b0, 3);
        underrun_clr = 1'b0;
        step();
        check("urun_clr_prio", 32'(underrun_cnt), 32'd0);

        // Randomized runs
        for (int it = 0; it < 8; it++) begin
            n_push = $urandom_range(0, 6);
            if (model_q.size() + n_push < NCH) n_push = NCH - model_q.size();
            if (model_q.size() + n_push > DEPTH) n_push = DEPTH - model_q.size();
            for (int k = 0; k < n_push; k++) push(W'($urandom));
            run_stream($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end

        // Fill to full, overflow attempt, then reset in the middle of RUN
        do_reset();
        for (int k = 0; k < DEPTH; k++) push(W'($urandom));
        check("full_ready", 32'(wr_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'd16);
        wr_valid = 1'b1;
        wr_data  = 10'h2AA;
        step();
        wr_valid = 1'b0;
        check("overflow_level", 32'(fifo_level), 32'd16);
        ctl_rate_div   = 16'd2;
        ctl_offset_bin = 1'b0;
        ctl_enable     = 1'b1;
        step();
        step();
        model_ch = 0;
        for (int t = 0; t < 3; t++) begin
            repeat (3) step();
            expect_tick();
        end
        check("prereset_level", 32'(fifo_level), 32'd13);
        Bus2IP_Reset = 1'b1;
        step();
        check_zero("midrun_reset");
        Bus2IP_Reset = 1'b0;
        ctl_enable   = 1'b0;
        model_clear();
        step();
        check("post_reset_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
